ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver running on the system clock rather than on the PS/2 clock. It synchronises ps2_clk/ps2_data, detects falling edges of ps2_clk and deserialises 11-bit frames (start, data LSB-first, odd parity, stop). It checks parity and framing, recovers from stalled frames via a timeout, and buffers good bytes in a show-ahead FIFO. It sits between the keyboard pins and the scan-code decode / seven-segment display logic.

Parameters:
DATA_BITS, 8, payload bits per frame (LSB first)
FIFO_DEPTH, 4, number of buffered bytes (power of 2, >=2)
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data (>=2)
TIMEOUT_CYCLES, 50000, clk cycles allowed between ps2_clk falling edges inside a frame

Ports:
clk  in  1  system clock; only clock in the block
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
rd_en  in  1  pop request; honoured only when valid=1
valid  out  1  FIFO non-empty; data_out holds oldest byte
data_out  out  DATA_BITS  head of FIFO (show-ahead)
parity_err  out  1  one-cycle pulse: frame dropped, bad parity
frame_err  out  1  one-cycle pulse: frame dropped, stop bit 0 or timeout
overflow  out  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, bit counter=0, timeout counter=0, FIFO emptied. valid=0, data_out=0, and all error pulses=0 on the first clk edge with reset=1. Reset mid-frame discards the partial frame.
- Sync chains preset to 1 (idle bus level). A fall is sampled when the previous synced ps2_clk=1 and the current one=0. Detection occurs SYNC_STAGES+1 clk cycles after the pin falls. All bit sampling uses synced ps2_data on that cycle.
- FSM states (ps2_pkg::rx_state_t): IDLE, DATA, PARITY, STOP.
  - IDLE: on fall, if data=0 go to DATA with cnt=0. If data=1, ignore the fall and stay in IDLE.
  - DATA: on each fall shift data into the MSB of the shift register (right shift), cnt++. When cnt reaches DATA_BITS-1 on a fall, go to PARITY. After DATA_BITS falls, shreg[0] is the first bit received.
  - PARITY: on fall capture the parity bit and go to STOP.
  - STOP: on fall go to IDLE and resolve the frame on the same clk edge:
    - stop=0: frame_err pulse.
    - else XOR(data, parity)=0: parity_err pulse.
    - else FIFO full and no pop this cycle: overflow pulse.
    - else push to FIFO.
  - Exactly one outcome per frame.
- Latency: pushed byte visible (valid=1, data_out updated) on the clk edge after the stop-bit fall is detected.
- Timeout: in DATA/PARITY/STOP the counter increments each clk and clears on every fall. At TIMEOUT_CYCLES-1 with no fall: go to IDLE, frame_err pulse, counter cleared. In IDLE the counter is held at 0. A fall on the same cycle as expiry wins (no timeout).
- FIFO: circular buffer with wr/rd pointers of $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH, and a count of $clog2(FIFO_DEPTH)+1 bits.
  - Pop when rd_en & valid. rd_en while empty is ignored, with no state change.
  - Push and pop on the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop on the same cycle when count=1: valid stays 1, data_out shows the new byte.
  - data_out holds the last head value when empty.
- Error pulses are never asserted together and never in two consecutive cycles from one frame.

Decomposition:
- ps2_pkg: rx_state_t enum; PS2_FRAME_BITS=11 (for DATA_BITS=8); helper function odd_parity_ok(data, p).
- Sub-module ps2_sync_fifo (params WIDTH, DEPTH; ports clk, reset, push, din, pop, dout, valid, full). It is reused by the future host-to-device transmitter.
- Synchroniser and edge detect stay inline.

Test Plan:
1. Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1), rd_en=0 -> valid rises the cycle after the stop fall is detected, data_out=0x1C, no error pulses.
2. 0x1C with parity=1 -> one parity_err pulse, valid stays 0. Then frame 0xF0 (parity 1) -> data_out=0xF0.
3. 5 good frames 0x01..0x05, rd_en=0, FIFO_DEPTH=4 -> fifth frame gives an overflow pulse. Popping yields 0x01,0x02,0x03,0x04, then valid=0. Next pop on empty changes nothing.
4. Stop frame after 4 data bits (ps2_clk held 1) -> frame_err pulse at TIMEOUT_CYCLES clk after the last fall, FSM in IDLE. The next full frame 0x5A is received correctly.
5. Reset asserted for 1 cycle mid-frame with FIFO holding 2 bytes -> next cycle valid=0, data_out=0. A subsequent frame 0x29 is received alone.
6. FIFO full, rd_en=1 on the stop-fall cycle of frame 0x66 -> no overflow, count stays 4, 0x66 is the last byte popped.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ps2_pkg
// Purpose  : Shared types and helpers for the PS/2 receive and transmit paths
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  // Returns 1 when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [31:0] data, input logic p);
    return (^data) ^ p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_fifo
// Purpose  : Single-clock show-ahead FIFO; dout is registered and holds the
//            last head value once the FIFO drains
// Revision : 1.0 - initial release
// ============================================================================
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_dout;
  logic [c_ptr_w-1:0] w_rd_next;
  logic               w_do_pop;
  logic               w_do_push;

  assign valid     = (r_count != '0);
  assign full      = (r_count == c_cnt_full);
  assign dout      = r_dout;
  assign w_do_pop  = pop & valid;
  // A pop on the same edge frees the slot, so a full FIFO still accepts a push
  assign w_do_push = push & (~full | w_do_pop);
  assign w_rd_next = r_rd_ptr + c_ptr_one;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      // The incoming byte becomes the head when it lands in an empty FIFO or
      // replaces the only entry being popped; otherwise the next slot moves up.
      if (w_do_push && ((r_count == '0) || (w_do_pop && (r_count == c_cnt_one)))) begin
        r_dout <= din;
      end else if (w_do_pop && (r_count != c_cnt_one)) begin
        r_dout <= r_mem[w_rd_next];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver on the system clock with parity,
//            framing and timeout checks feeding a show-ahead byte FIFO
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 rd_en,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int c_cnt_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_BITS - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  // Synchroniser and falling-edge detect
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  // Frame FSM state
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] w_shreg_nxt;
  logic                 r_par;
  logic                 w_par_nxt;
  logic [c_tmo_w-1:0]   r_tmo;
  logic [c_tmo_w-1:0]   w_tmo_nxt;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overflow;
  logic                 w_perr_nxt;
  logic                 w_ferr_nxt;
  logic                 w_ovf_nxt;
  logic                 w_tmo_hit;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_valid;
  logic                 w_full;

  assign w_pop = rd_en & w_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_par        <= 1'b0;
      r_tmo        <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_par        <= w_par_nxt;
      r_tmo        <= w_tmo_nxt;
      r_parity_err <= w_perr_nxt;
      r_frame_err  <= w_ferr_nxt;
      r_overflow   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_par_nxt   = r_par;
    w_tmo_nxt   = '0;
    w_perr_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_push      = 1'b0;

    // A fall on the expiry cycle keeps the frame alive
    w_tmo_hit = (r_state != IDLE) && !w_fall && (r_tmo == c_tmo_last);

    if ((r_state != IDLE) && !w_fall && !w_tmo_hit) begin
      w_tmo_nxt = r_tmo + c_tmo_one;
    end

    if (w_tmo_hit) begin
      w_state_nxt = IDLE;
      w_ferr_nxt  = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_data_s) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = '0;
          end
        end
        DATA: begin
          w_shreg_nxt = {w_data_s, r_shreg[DATA_BITS-1:1]};
          w_cnt_nxt   = r_cnt + c_cnt_one;
          if (r_cnt == c_cnt_last) begin
            w_state_nxt = PARITY;
          end
        end
        PARITY: begin
          w_par_nxt   = w_data_s;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (!w_data_s) begin
            w_ferr_nxt = 1'b1;
          end else if (!odd_parity_ok(32'(r_shreg), r_par)) begin
            w_perr_nxt = 1'b1;
          end else if (w_full && !w_pop) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  ps2_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (r_shreg),
    .pop   (w_pop),
    .dout  (data_out),
    .valid (w_valid),
    .full  (w_full)
  );

  assign valid      = w_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Purpose  : Directed, table-driven self-checking bench for ps2_rx_fifo
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       valid;
  logic [7:0] data_out;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_errs   = 0;
  int n_perr   = 0;
  int n_ferr   = 0;
  int n_ovf    = 0;

  ps2_rx_fifo #(
    .DATA_BITS      (8),
    .FIFO_DEPTH     (4),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .valid      (valid),
    .data_out   (data_out),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         stop;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_perr;
    int         exp_ferr;
    int         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Pulse counting and mutual exclusion of the error outputs
  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (overflow)   n_ovf++;
    if (parity_err | frame_err | overflow) begin
      n_checks++;
      if ((int'(parity_err) + int'(frame_err) + int'(overflow)) > 1) begin
        n_errs++;
        $display("FAIL pulse_exclusive actual=%b%b%b required=one-hot",
                 parity_err, frame_err, overflow);
      end
    end
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit,
                            input bit chk_lat, input bit pop_stop);
    logic p;
    p = ~(^d) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    @(negedge clk);
    ps2_data = stop_bit;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    if (chk_lat) chk("lat_valid_before", valid, 1'b0);
    if (pop_stop) rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (chk_lat) begin
      chk("lat_valid_after", valid, 1'b1);
      chk("lat_data_after", data_out, d);
    end
    repeat (7) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic timeout_frame();
    int f0;
    f0 = n_ferr;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    for (int k = 1; k <= TMO + 4; k++) begin
      @(negedge clk);
      if (k == 10) ps2_clk = 1'b1;
      if (k == TMO + 2) chk("tmo_before", frame_err, 1'b0);
      if (k == TMO + 3) chk("tmo_pulse", frame_err, 1'b1);
    end
    chk("tmo_count", n_ferr - f0, 1);
  endtask

  initial begin
    int p0, f0, o0;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 0, 0, 0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h1C, 1, 0, 0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'hF0, 0, 0, 0};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hF0, 0, 1, 0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 0, 0, 0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'hFF, 1, 0, 0};
    vecs[7] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'hFF, 0, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_pulses", {parity_err, frame_err, overflow}, 3'b000);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // First frame with latency check
    p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1_pulses", (n_perr - p0) + (n_ferr - f0) + (n_ovf - o0), 0);
    pop();
    chk("t1_empty", valid, 1'b0);

    // Table of single frames on an empty FIFO
    for (int i = 0; i < 8; i++) begin
      p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
      send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop, 1'b0, 1'b0);
      chk($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
      chk($sformatf("vec%0d_perr", i), n_perr - p0, vecs[i].exp_perr);
      chk($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovf", i), n_ovf - o0, vecs[i].exp_ovf);
      if (vecs[i].exp_valid) begin
        pop();
        chk($sformatf("vec%0d_drain", i), valid, 1'b0);
        chk($sformatf("vec%0d_hold", i), data_out, vecs[i].exp_data);
      end
    end

    // Overflow on the fifth byte
    o0 = n_ovf;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf_none_at_4", n_ovf - o0, 0);
    send_frame(8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf_pulse", n_ovf - o0, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovf_pop%0d_data", i), data_out, 8'(i));
      chk($sformatf("ovf_pop%0d_valid", i), valid, 1'b1);
      pop();
    end
    chk("ovf_empty", valid, 1'b0);
    pop();
    chk("empty_pop_valid", valid, 1'b0);
    chk("empty_pop_data", data_out, 8'h04);

    // Stalled frame then recovery
    timeout_frame();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tmo_recover_valid", valid, 1'b1);
    chk("tmo_recover_data", data_out, 8'h5A);
    pop();

    // Reset mid-frame with two bytes buffered
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_pre_data", data_out, 8'h11);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_data", data_out, 8'h00);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_29_valid", valid, 1'b1);
    chk("mid_29_data", data_out, 8'h29);
    pop();
    chk("mid_29_alone", valid, 1'b0);

    // Full FIFO with a pop on the stop-fall cycle
    for (int i = 1; i <= 4; i++) send_frame(8'h60 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    o0 = n_ovf;
    send_frame(8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("full_pop_no_ovf", n_ovf - o0, 0);
    chk("full_pop_head", data_out, 8'h62);
    pop();
    chk("full_pop_d63", data_out, 8'h63);
    pop();
    chk("full_pop_d64", data_out, 8'h64);
    pop();
    chk("full_pop_d66", data_out, 8'h66);
    chk("full_pop_v66", valid, 1'b1);
    pop();
    chk("full_pop_empty", valid, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
